// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller: forward-select codes
// and the multi-cycle execute FSM state type.
package hazard_pkg;
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic {
    MC_IDLE = 1'b0,
    MC_BUSY = 1'b1
  } mc_state_e;
endpackage

// File: rtl/hazard_ctrl_unit_if.sv
// Hazard controller bundle: pipeline-side hazard inputs and the stage
// enable/flush/forward outputs. The master drives inputs, the slave is the unit.
interface hazard_ctrl_unit_if #(
  parameter int REG_AW  = 5,
  parameter int NUM_SRC = 2,
  parameter int CNT_W   = 16
);
  logic [NUM_SRC*REG_AW-1:0] rs_d, rs_e;
  logic [REG_AW-1:0]         rd_e, rd_m, rd_w;
  logic                      reg_write_m, reg_write_w;
  logic                      result_src_e, pc_src_e, mc_start_e;
  logic [2*NUM_SRC-1:0]      forward_e;
  logic                      stall_f, stall_d, stall_e;
  logic                      flush_d, flush_e, flush_m;
  logic                      mc_busy;
  logic [CNT_W-1:0]          stall_cnt, flush_cnt;

  modport master (
    output rs_d, rs_e, rd_e, rd_m, rd_w, reg_write_m, reg_write_w,
           result_src_e, pc_src_e, mc_start_e,
    input  forward_e, stall_f, stall_d, stall_e, flush_d, flush_e, flush_m,
           mc_busy, stall_cnt, flush_cnt
  );

  modport slave (
    input  rs_d, rs_e, rd_e, rd_m, rd_w, reg_write_m, reg_write_w,
           result_src_e, pc_src_e, mc_start_e,
    output forward_e, stall_f, stall_d, stall_e, flush_d, flush_e, flush_m,
           mc_busy, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_fwd_mux_sel.sv
// Per-operand forward select for the E stage. M beats W; x0 is never forwarded.
module hazard_fwd_mux_sel
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs,
  input  logic [REG_AW-1:0] rd_m,
  input  logic [REG_AW-1:0] rd_w,
  input  logic              reg_write_m,
  input  logic              reg_write_w,
  output logic [1:0]        sel
);
  always_comb begin
    sel = FWD_RF;
    if (reg_write_m && (rd_m != '0) && (rd_m == rs))      sel = FWD_MEM;
    else if (reg_write_w && (rd_w != '0) && (rd_w == rs)) sel = FWD_WB;
  end
endmodule

// File: rtl/hazard_ctrl_unit.sv
// Unified hazard controller: forwarding, load-use stall, branch flush and the
// multi-cycle execute hold FSM. Perf counters built only with HAZARD_PERF_CNT_EN.
module hazard_ctrl_unit
  import hazard_pkg::*;
#(
  parameter int REG_AW  = 5,
  parameter int NUM_SRC = 2,
  parameter int MC_LAT  = 4,
  parameter int CNT_W   = 16
) (
  input logic               clk,
  input logic               rst,
  hazard_ctrl_unit_if.slave bus
);
  localparam int              CW       = $clog2(MC_LAT + 1);
  localparam bit              MC_MULTI = (MC_LAT > 1);
  localparam logic [CW-1:0]   MC_LOAD  = CW'(MC_LAT - 1);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);

  logic [NUM_SRC-1:0][REG_AW-1:0] rs_d_a, rs_e_a;
  logic [NUM_SRC-1:0][1:0]        fwd_a;

  assign rs_d_a = bus.rs_d;
  assign rs_e_a = bus.rs_e;

  for (genvar k = 0; k < NUM_SRC; k++) begin : g_fwd
    hazard_fwd_mux_sel #(.REG_AW(REG_AW)) u_sel (
      .rs          (rs_e_a[k]),
      .rd_m        (bus.rd_m),
      .rd_w        (bus.rd_w),
      .reg_write_m (bus.reg_write_m),
      .reg_write_w (bus.reg_write_w),
      .sel         (fwd_a[k])
    );
  end

  assign bus.forward_e = fwd_a;

  logic lu;
  always_comb begin
    lu = 1'b0;
    for (int k = 0; k < NUM_SRC; k++)
      if (rs_d_a[k] == bus.rd_e) lu = 1'b1;
    lu = lu && bus.result_src_e && (bus.rd_e != '0);
  end

  // mc_cnt counts remaining E cycles; the hold drops on the op's last E cycle
  mc_state_e     state_q, state_d;
  logic [CW-1:0] mc_cnt_q, mc_cnt_d;
  logic          mc_hold;

  always_comb begin
    state_d  = state_q;
    mc_cnt_d = mc_cnt_q;
    mc_hold  = 1'b0;
    case (state_q)
      MC_IDLE: if (bus.mc_start_e && MC_MULTI) begin
        state_d  = MC_BUSY;
        mc_cnt_d = MC_LOAD;
        mc_hold  = 1'b1;
      end
      MC_BUSY: begin
        mc_hold  = (mc_cnt_q > CNT_ONE);
        mc_cnt_d = mc_cnt_q - CNT_ONE;
        if (mc_cnt_q == CNT_ONE) state_d = MC_IDLE;
      end
      default: state_d = MC_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= MC_IDLE;
      mc_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      mc_cnt_q <= mc_cnt_d;
    end
  end

  // Hold masks branch and load-use; a taken branch discards the load-use victim in D
  logic stall_f, flush_d, flush_e;
  assign stall_f     = ~rst & (mc_hold | (~bus.pc_src_e & lu));
  assign flush_d     = ~rst & ~mc_hold & bus.pc_src_e;
  assign flush_e     = ~rst & ~mc_hold & (bus.pc_src_e | lu);

  assign bus.stall_f = stall_f;
  assign bus.stall_d = stall_f;
  assign bus.stall_e = ~rst & mc_hold;
  assign bus.flush_d = flush_d;
  assign bus.flush_e = flush_e;
  assign bus.flush_m = ~rst & mc_hold;
  assign bus.mc_busy = (state_q == MC_BUSY);

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_f && (stall_cnt_q != '1))               stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if ((flush_d || flush_e) && (flush_cnt_q != '1))  flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.stall_cnt = stall_cnt_q;
  assign bus.flush_cnt = flush_cnt_q;
`else
  assign bus.stall_cnt = {CNT_W{1'b0}};
  assign bus.flush_cnt = {CNT_W{1'b0}};
`endif
endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Self-checking bench for hazard_ctrl_unit: directed scenarios with literal
// expectations plus randomized traffic against a cycle-indexed reference model.
module tb_hazard_ctrl_unit;
  localparam int REG_AW = 5;
  localparam int NS     = 2;
  localparam int MC_LAT = 4;
  localparam int CNT_W  = 4;
  localparam int SAT    = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_ctrl_unit_if #(.REG_AW(REG_AW), .NUM_SRC(NS), .CNT_W(CNT_W)) bus ();

  hazard_ctrl_unit #(.REG_AW(REG_AW), .NUM_SRC(NS), .MC_LAT(MC_LAT), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0, n_err = 0;
  // model state: cycle index, start cycle of the current multi-cycle op, event counts
  int cyc = 0, mc_t0 = -1, sc_i = 0, fc_i = 0;

  // ctl = {stall_f, stall_d, stall_e, flush_d, flush_e, flush_m, mc_busy}
  logic [6:0] act_ctl;
  assign act_ctl = {bus.stall_f, bus.stall_d, bus.stall_e, bus.flush_d,
                    bus.flush_e, bus.flush_m, bus.mc_busy};

  typedef struct packed {
    logic [2*NS-1:0]  fwd;
    logic [6:0]       ctl;
    logic [CNT_W-1:0] sc;
    logic [CNT_W-1:0] fc;
  } exp_t;

  function automatic exp_t model();
    exp_t e;
    logic busy, hold, lu, mh, wh;
    logic [REG_AW-1:0] r;
    e = '0;
    for (int k = 0; k < NS; k++) begin
      r  = bus.rs_e[k*REG_AW +: REG_AW];
      mh = bus.reg_write_m && (bus.rd_m != 0) && (bus.rd_m == r);
      wh = bus.reg_write_w && (bus.rd_w != 0) && (bus.rd_w == r);
      e.fwd[2*k +: 2] = mh ? 2'b10 : (wh ? 2'b01 : 2'b00);
    end
    busy = (mc_t0 >= 0) && (cyc > mc_t0) && (cyc < mc_t0 + MC_LAT);
    hold = busy ? (cyc < mc_t0 + MC_LAT - 1) : (bus.mc_start_e && (MC_LAT > 1));
    lu = 1'b0;
    for (int k = 0; k < NS; k++)
      if (bus.rs_d[k*REG_AW +: REG_AW] == bus.rd_e) lu = 1'b1;
    lu = lu && bus.result_src_e && (bus.rd_e != 0);
    if (!rst)
      e.ctl = {hold || (!bus.pc_src_e && lu), hold || (!bus.pc_src_e && lu), hold,
               !hold && bus.pc_src_e, !hold && (bus.pc_src_e || lu), hold, busy};
`ifdef HAZARD_PERF_CNT_EN
    e.sc = CNT_W'((sc_i > SAT) ? SAT : sc_i);
    e.fc = CNT_W'((fc_i > SAT) ? SAT : fc_i);
`endif
    return e;
  endfunction

  task automatic tick();
    exp_t e;
    e = model();
    @(posedge clk);
    if (rst) begin
      mc_t0 = -1; sc_i = 0; fc_i = 0;
    end else begin
      if (!e.ctl[0] && bus.mc_start_e && (MC_LAT > 1)) mc_t0 = cyc;
      if (e.ctl[6]) sc_i++;
      if (e.ctl[3] || e.ctl[2]) fc_i++;
    end
    cyc++;
    #1;
  endtask

  task automatic clear_inputs();
    bus.rs_d = '0; bus.rs_e = '0; bus.rd_e = '0; bus.rd_m = '0; bus.rd_w = '0;
    bus.reg_write_m = 0; bus.reg_write_w = 0; bus.result_src_e = 0;
    bus.pc_src_e = 0; bus.mc_start_e = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    mc_t0 = -1; sc_i = 0; fc_i = 0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    bus.rd_m = 5; bus.reg_write_m = 1; bus.rs_e[0 +: REG_AW] = 5;
    bus.result_src_e = 1; bus.rd_e = 7; bus.rs_d[REG_AW +: REG_AW] = 7;
    bus.pc_src_e = 1; bus.mc_start_e = 1;
    #2;
    n_cmp++;
    if (act_ctl !== 7'b0) begin n_err++; $display("FAIL reset_ctl got=%b exp=%b", act_ctl, 7'b0); end
    n_cmp++;
    if ({bus.stall_cnt, bus.flush_cnt} !== '0) begin
      n_err++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", bus.stall_cnt, bus.flush_cnt);
    end
    n_cmp++;
    if (bus.forward_e[1:0] !== 2'b10) begin n_err++; $display("FAIL reset_fwd got=%b exp=10", bus.forward_e[1:0]); end
    do_reset();
  endtask

  task automatic test_forward();
    clear_inputs();
    bus.rd_m = 5; bus.reg_write_m = 1; bus.rd_w = 5; bus.reg_write_w = 1;
    bus.rs_e[0 +: REG_AW] = 5;
    #1; n_cmp++;
    if (bus.forward_e !== 4'b0010) begin n_err++; $display("FAIL fwd_mem got=%b exp=0010", bus.forward_e); end
    bus.rd_m = 0;
    #1; n_cmp++;
    if (bus.forward_e !== 4'b0001) begin n_err++; $display("FAIL fwd_wb got=%b exp=0001", bus.forward_e); end
    bus.reg_write_w = 0; bus.rd_m = 5; bus.rs_e[REG_AW +: REG_AW] = 5;
    #1; n_cmp++;
    if (bus.forward_e !== 4'b1010) begin n_err++; $display("FAIL fwd_both got=%b exp=1010", bus.forward_e); end
    bus.rd_m = 0; bus.rd_w = 0; bus.reg_write_w = 1; bus.rs_e = '0;
    #1; n_cmp++;
    if (bus.forward_e !== 4'b0000) begin n_err++; $display("FAIL fwd_x0 got=%b exp=0000", bus.forward_e); end
    tick();
  endtask

  task automatic test_load_use();
    clear_inputs();
    bus.result_src_e = 1; bus.rd_e = 7; bus.rs_d[REG_AW +: REG_AW] = 7;
    #2; n_cmp++;
    if (act_ctl !== 7'b1100100) begin n_err++; $display("FAIL lu_stall got=%b exp=1100100", act_ctl); end
    tick();
    clear_inputs();
    #2; n_cmp++;
    if (act_ctl !== 7'b0) begin n_err++; $display("FAIL lu_one_cycle got=%b exp=0000000", act_ctl); end
    tick();
    bus.result_src_e = 1; bus.rd_e = 0;
    #2; n_cmp++;
    if (act_ctl !== 7'b0) begin n_err++; $display("FAIL lu_rd0 got=%b exp=0000000", act_ctl); end
    tick();
    clear_inputs();
  endtask

  task automatic test_branch();
    clear_inputs();
    bus.pc_src_e = 1; bus.result_src_e = 1; bus.rd_e = 7; bus.rs_d[0 +: REG_AW] = 7;
    #2; n_cmp++;
    if (act_ctl !== 7'b0001100) begin n_err++; $display("FAIL branch_lu got=%b exp=0001100", act_ctl); end
    tick();
    clear_inputs();
  endtask

  task automatic test_multicycle();
    logic [6:0] exp;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      clear_inputs();
      bus.mc_start_e = (i == 0 || i == 2);
      bus.pc_src_e   = (i == 1 || i == 3);
      exp = {(i <= 2), (i <= 2), (i <= 2), (i == 3), (i == 3), (i <= 2), (i >= 1 && i <= 3)};
      #2; n_cmp++;
      if (act_ctl !== exp) begin n_err++; $display("FAIL mc_seq cyc=%0d got=%b exp=%b", i, act_ctl, exp); end
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_back_to_back();
    logic se, bz;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      clear_inputs();
      bus.mc_start_e = (i == 0 || i == 3 || i == 4);
      se = (i <= 2) || (i >= 4 && i <= 6);
      bz = (i >= 1 && i <= 3) || (i >= 5 && i <= 7);
      #2; n_cmp++;
      if ({bus.stall_e, bus.mc_busy} !== {se, bz}) begin
        n_err++; $display("FAIL b2b cyc=%0d got=%b%b exp=%b%b", i, bus.stall_e, bus.mc_busy, se, bz);
      end
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_reset_busy();
    int n_st, n_bz;
    do_reset();
    bus.mc_start_e = 1;
    tick();
    clear_inputs();
    #2; n_cmp++;
    if ({bus.stall_e, bus.mc_busy} !== 2'b11) begin
      n_err++; $display("FAIL rb_busy got=%b%b exp=11", bus.stall_e, bus.mc_busy);
    end
    #1 rst = 1'b1;
    mc_t0 = -1; sc_i = 0; fc_i = 0;
    #1; n_cmp++;
    if (act_ctl !== 7'b0) begin n_err++; $display("FAIL rb_async got=%b exp=0000000", act_ctl); end
    tick();
    rst = 1'b0;
    n_st = 0; n_bz = 0;
    for (int i = 0; i < 7; i++) begin
      bus.mc_start_e = (i == 0);
      #2;
      if (bus.stall_e) n_st++;
      if (bus.mc_busy) n_bz++;
      tick();
    end
    n_cmp++;
    if (n_st != MC_LAT - 1 || n_bz != MC_LAT - 1) begin
      n_err++; $display("FAIL rb_rerun stall=%0d busy=%0d exp=%0d/%0d", n_st, n_bz, MC_LAT - 1, MC_LAT - 1);
    end
    clear_inputs();
  endtask

  task automatic test_random();
    exp_t e;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < NS; k++) begin
        bus.rs_d[k*REG_AW +: REG_AW] = REG_AW'($urandom_range(0, 3));
        bus.rs_e[k*REG_AW +: REG_AW] = REG_AW'($urandom_range(0, 3));
      end
      bus.rd_e = REG_AW'($urandom_range(0, 3));
      bus.rd_m = REG_AW'($urandom_range(0, 3));
      bus.rd_w = REG_AW'($urandom_range(0, 3));
      bus.reg_write_m  = 1'($urandom_range(0, 1));
      bus.reg_write_w  = 1'($urandom_range(0, 1));
      bus.result_src_e = ($urandom_range(0, 9) < 3);
      bus.pc_src_e     = ($urandom_range(0, 9) < 2);
      bus.mc_start_e   = ($urandom_range(0, 9) < 1);
      #2;
      e = model();
      n_cmp++;
      if (bus.forward_e !== e.fwd) begin n_err++; $display("FAIL rnd_fwd cyc=%0d got=%b exp=%b", i, bus.forward_e, e.fwd); end
      n_cmp++;
      if (act_ctl !== e.ctl) begin n_err++; $display("FAIL rnd_ctl cyc=%0d got=%b exp=%b", i, act_ctl, e.ctl); end
      n_cmp++;
      if ({bus.stall_cnt, bus.flush_cnt} !== {e.sc, e.fc}) begin
        n_err++; $display("FAIL rnd_cnt cyc=%0d got=%0d/%0d exp=%0d/%0d", i, bus.stall_cnt, bus.flush_cnt, e.sc, e.fc);
      end
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_counters();
    logic [CNT_W-1:0] exp10, exp20;
`ifdef HAZARD_PERF_CNT_EN
    exp10 = CNT_W'(10); exp20 = CNT_W'(15);
`else
    exp10 = '0; exp20 = '0;
`endif
    do_reset();
    bus.result_src_e = 1; bus.rd_e = 7; bus.rs_d[REG_AW +: REG_AW] = 7;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i == 9) begin
        #2; n_cmp++;
        if ({bus.stall_cnt, bus.flush_cnt} !== {exp10, exp10}) begin
          n_err++; $display("FAIL cnt_10 got=%0d/%0d exp=%0d/%0d", bus.stall_cnt, bus.flush_cnt, exp10, exp10);
        end
      end
    end
    #2; n_cmp++;
    if ({bus.stall_cnt, bus.flush_cnt} !== {exp20, exp20}) begin
      n_err++; $display("FAIL cnt_sat got=%0d/%0d exp=%0d/%0d", bus.stall_cnt, bus.flush_cnt, exp20, exp20);
    end
    clear_inputs();
    tick();
  endtask

  initial begin
    test_reset();
    test_forward();
    test_load_use();
    test_branch();
    test_multicycle();
    test_back_to_back();
    test_reset_busy();
    test_random();
    test_counters();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
